sig_mel_bank: RTL and testbench

Parametrised mel filter-bank reducer. It consumes one frame of N_BINS unsigned spectrum magnitudes and emits exactly N_BANDS band values per frame. Each band value is either the maximum or the saturating sum of the bins in that band. Band boundaries come from an external synchronous edge table (1-cycle read latency). The block sits between the spectrum stage and the feature/normalisation stage.

---
 rtl/sig_mel_bank.sv | 152 +++++++++++++++
 tb/tb_sig_mel_bank.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sig_mel_bank.sv
// Mel filter-bank reducer: folds one frame of N_BINS spectrum bins into N_BANDS band values
// (max or saturating sum), with band edges read from an external 1-cycle-latency table.
module sig_mel_bank #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned N_BINS  = 256,
  parameter int unsigned N_BANDS = 32,
  parameter int unsigned MODE    = 0,
  localparam int unsigned BIN_AW  = $clog2(N_BINS),
  localparam int unsigned BAND_AW = (N_BANDS > 1) ? $clog2(N_BANDS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init,
  input  logic [DATA_W-1:0]  spect_data,
  input  logic               spect_valid,
  output logic               spect_rdy,
  output logic [DATA_W-1:0]  mel_data,
  output logic               mel_valid,
  output logic               mel_last,
  input  logic               mel_rdy,
  output logic [BAND_AW-1:0] tbl_addr,
  input  logic [BIN_AW-1:0]  tbl_data
);

  localparam int unsigned CNT_W = BIN_AW + 1;

  typedef enum logic [2:0] {StFetch, StWait, StAccept, StEmit, StDrain} state_e;

  state_e              state_q, state_d;
  logic [BAND_AW-1:0]  band_q, band_d;
  logic [CNT_W-1:0]    bin_cnt_q, bin_cnt_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [BIN_AW-1:0]   edge_q, edge_d;

  logic [BIN_AW-1:0]   edge_clamp;
  logic [DATA_W:0]     sum;
  logic [DATA_W-1:0]   max_v, sat_v, acc_upd;
  logic                last_band;

  assign last_band = (band_q == BAND_AW'(N_BANDS - 1));

  always_comb begin
    edge_clamp = tbl_data;
    if ({1'b0, tbl_data} >= CNT_W'(N_BINS)) begin
      edge_clamp = BIN_AW'(N_BINS - 1);
    end
    sum     = {1'b0, acc_q} + {1'b0, spect_data};
    max_v   = (spect_data > acc_q) ? spect_data : acc_q;
    sat_v   = sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
    acc_upd = (MODE == 0) ? max_v : sat_v;
  end

  always_comb begin
    state_d   = state_q;
    band_d    = band_q;
    bin_cnt_d = bin_cnt_q;
    acc_d     = acc_q;
    edge_d    = edge_q;

    unique case (state_q)
      StFetch: state_d = StWait;

      StWait: begin
        edge_d = edge_clamp;
        // Empty band: the previous band already consumed past this edge, or the frame is used up.
        if ((bin_cnt_q > {1'b0, edge_clamp}) || (bin_cnt_q == CNT_W'(N_BINS))) begin
          acc_d   = '0;
          state_d = StEmit;
        end else begin
          state_d = StAccept;
        end
      end

      StAccept: begin
        if (spect_valid) begin
          acc_d     = acc_upd;
          bin_cnt_d = bin_cnt_q + CNT_W'(1);
          if (bin_cnt_q == {1'b0, edge_q}) begin
            state_d = StEmit;
          end
        end
      end

      StEmit: begin
        if (mel_rdy) begin
          acc_d = '0;
          if (!last_band) begin
            band_d  = band_q + BAND_AW'(1);
            state_d = StFetch;
          end else if (bin_cnt_q < CNT_W'(N_BINS)) begin
            state_d = StDrain;
          end else begin
            bin_cnt_d = '0;
            band_d    = '0;
            state_d   = StFetch;
          end
        end
      end

      StDrain: begin
        if (spect_valid) begin
          bin_cnt_d = bin_cnt_q + CNT_W'(1);
          if (bin_cnt_q == CNT_W'(N_BINS - 1)) begin
            bin_cnt_d = '0;
            band_d    = '0;
            state_d   = StFetch;
          end
        end
      end

      default: state_d = StFetch;
    endcase

    if (init) begin
      state_d   = StFetch;
      band_d    = '0;
      bin_cnt_d = '0;
      acc_d     = '0;
      edge_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetch;
      band_q    <= '0;
      bin_cnt_q <= '0;
      acc_q     <= '0;
      edge_q    <= '0;
    end else begin
      state_q   <= state_d;
      band_q    <= band_d;
      bin_cnt_q <= bin_cnt_d;
      acc_q     <= acc_d;
      edge_q    <= edge_d;
    end
  end

  // Handshakes are masked during rst/init so nothing is consumed in those cycles.
  always_comb begin
    spect_rdy = 1'b0;
    mel_valid = 1'b0;
    if (!rst && !init) begin
      spect_rdy = (state_q == StAccept) || (state_q == StDrain);
      mel_valid = (state_q == StEmit);
    end
    mel_data = mel_valid ? acc_q : '0;
    mel_last = mel_valid && last_band;
    tbl_addr = band_q;
  end

endmodule

// File: tb/tb_sig_mel_bank.sv
// Bench for sig_mel_bank: max and saturating-sum instances share stimulus; a frame-level
// reference model fills per-instance scoreboards that a separate monitor drains.
module tb_sig_mel_bank;

  localparam int unsigned DW      = 8;
  localparam int unsigned NBINS   = 8;
  localparam int unsigned NBANDS  = 3;
  localparam int unsigned BIN_AW  = 3;
  localparam int unsigned BAND_AW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst = 1'b1;
  logic               init = 1'b0;
  logic               spect_valid = 1'b0;
  logic [DW-1:0]      spect_data = '0;
  logic               mel_rdy = 1'b0;
  logic               spect_rdy0, spect_rdy1, mel_valid0, mel_valid1, mel_last0, mel_last1;
  logic [DW-1:0]      mel_data0, mel_data1;
  logic [BAND_AW-1:0] tbl_addr0, tbl_addr1;
  logic [BIN_AW-1:0]  tbl_data0, tbl_data1;

  logic [BIN_AW-1:0]  tbl [4];
  int                 frame_bins [NBINS];

  typedef struct {
    int data;
    bit last;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;
  int   frames_done = 0;
  int   frames_exp = 0;
  bit   rdy_low = 1'b0;
  bit   pend [2];
  int   pd [2];
  bit   pl [2];

  sig_mel_bank #(.DATA_W(DW), .N_BINS(NBINS), .N_BANDS(NBANDS), .MODE(0)) u_max (
    .clk(clk), .rst(rst), .init(init),
    .spect_data(spect_data), .spect_valid(spect_valid), .spect_rdy(spect_rdy0),
    .mel_data(mel_data0), .mel_valid(mel_valid0), .mel_last(mel_last0), .mel_rdy(mel_rdy),
    .tbl_addr(tbl_addr0), .tbl_data(tbl_data0)
  );

  sig_mel_bank #(.DATA_W(DW), .N_BINS(NBINS), .N_BANDS(NBANDS), .MODE(1)) u_sum (
    .clk(clk), .rst(rst), .init(init),
    .spect_data(spect_data), .spect_valid(spect_valid), .spect_rdy(spect_rdy1),
    .mel_data(mel_data1), .mel_valid(mel_valid1), .mel_last(mel_last1), .mel_rdy(mel_rdy),
    .tbl_addr(tbl_addr1), .tbl_data(tbl_data1)
  );

  // Synchronous edge table, one read port per instance.
  always @(posedge clk) begin
    tbl_data0 <= tbl[tbl_addr0];
    tbl_data1 <= tbl[tbl_addr1];
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: band b spans from the first unconsumed bin to clamp(edge[b]); empty gives 0.
  task automatic push_expected();
    int nxt;
    exp_t e;
    nxt = 0;
    for (int b = 0; b < int'(NBANDS); b++) begin
      int ed;
      int mx;
      int sm;
      ed = int'(tbl[b]);
      if (ed > int'(NBINS) - 1) ed = int'(NBINS) - 1;
      mx = 0;
      sm = 0;
      if (nxt <= ed && nxt < int'(NBINS)) begin
        for (int i = nxt; i <= ed; i++) begin
          if (frame_bins[i] > mx) mx = frame_bins[i];
          sm += frame_bins[i];
        end
        nxt = ed + 1;
      end
      if (sm > 255) sm = 255;
      e.last = (b == int'(NBANDS) - 1);
      e.data = mx;
      q0.push_back(e);
      e.data = sm;
      q1.push_back(e);
    end
    frames_exp++;
  endtask

  task automatic mon_one(input int k, input logic v, input logic [DW-1:0] d, input logic l);
    exp_t e;
    int   qs;
    if (pend[k]) begin
      check($sformatf("hold_valid%0d", k), int'(v), 1);
      check($sformatf("hold_data%0d", k), int'(d), pd[k]);
      check($sformatf("hold_last%0d", k), int'(l), int'(pl[k]));
    end
    pend[k] = 1'b0;
    if (v) begin
      if (mel_rdy) begin
        qs = (k == 0) ? q0.size() : q1.size();
        if (qs == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out%0d: got data %0d, required no output", k, d);
        end else begin
          e = (k == 0) ? q0.pop_front() : q1.pop_front();
          check($sformatf("band_data%0d", k), int'(d), e.data);
          check($sformatf("band_last%0d", k), int'(l), int'(e.last));
          if (k == 0 && e.last) frames_done++;
        end
      end else begin
        pend[k] = 1'b1;
        pd[k]   = int'(d);
        pl[k]   = l;
      end
    end
  endtask

  // Monitor samples 1 time unit before each rising edge.
  initial begin
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    forever begin
      @(negedge clk);
      #4;
      if (rst || init) begin
        pend[0] = 1'b0;
        pend[1] = 1'b0;
      end else begin
        if (mel_valid0) check("srdy_low_in_emit", int'(spect_rdy0), 0);
        mon_one(0, mel_valid0, mel_data0, mel_last0);
        mon_one(1, mel_valid1, mel_data1, mel_last1);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      mel_rdy = rdy_low ? 1'b0 : ($urandom_range(3) != 0);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    spect_valid = 1'b0;
    init = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    q0.delete();
    q1.delete();
    frames_done = 0;
    frames_exp = 0;
    #4;
    check("rst_spect_rdy", int'(spect_rdy0), 0);
    check("rst_mel_valid", int'(mel_valid0 | mel_valid1), 0);
    check("rst_mel_last", int'(mel_last0), 0);
    check("rst_mel_data", int'(mel_data0), 0);
    check("rst_tbl_addr", int'(tbl_addr0), 0);
  endtask

  task automatic stream_frame(input int n, input bit cont);
    int i;
    int guard;
    i = 0;
    guard = 0;
    while (i < n && guard < 400) begin
      @(negedge clk);
      spect_valid = cont ? 1'b1 : ($urandom_range(3) != 0);
      spect_data  = DW'(frame_bins[i]);
      #4;
      if (spect_valid && spect_rdy0) i++;
      guard++;
    end
    @(negedge clk);
    spect_valid = 1'b0;
    if (i < n) begin
      checks++;
      errors++;
      $display("FAIL bin_accept_timeout: got %0d bins, required %0d", i, n);
    end
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    while (frames_done < frames_exp && g < 300) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (frames_done < frames_exp) begin
      errors++;
      $display("FAIL frame_timeout: got %0d frames, required %0d", frames_done, frames_exp);
      do_reset();
    end
  endtask

  task automatic set_tbl(input int e0, input int e1, input int e2);
    tbl[0] = BIN_AW'(e0);
    tbl[1] = BIN_AW'(e1);
    tbl[2] = BIN_AW'(e2);
    tbl[3] = '1;
  endtask

  task automatic ramp_bins();
    for (int i = 0; i < int'(NBINS); i++) frame_bins[i] = i + 1;
  endtask

  task automatic run_frame(input int e0, input int e1, input int e2, input bit cont);
    set_tbl(e0, e1, e2);
    push_expected();
    stream_frame(int'(NBINS), cont);
    wait_done();
  endtask

  task automatic wait_mel_valid();
    int g;
    g = 0;
    while (!mel_valid0 && g < 50) begin
      @(negedge clk);
      #4;
      g++;
    end
    check("mel_valid_seen", int'(mel_valid0), 1);
  endtask

  initial begin
    set_tbl(7, 7, 7);
    ramp_bins();
    do_reset();

    // Contiguous bands, back-to-back frames restart at band 0.
    run_frame(2, 5, 7, 1'b1);
    run_frame(2, 5, 7, 1'b1);
    // Empty middle band.
    run_frame(2, 2, 7, 1'b0);
    // Saturation in the sum instance, trailing empty band.
    frame_bins[0] = 200;
    frame_bins[1] = 100;
    for (int i = 2; i < int'(NBINS); i++) frame_bins[i] = 1;
    run_frame(1, 7, 7, 1'b0);
    // Table ends early: bins 4..7 drained, next frame aligned.
    for (int i = 0; i < int'(NBINS); i++) frame_bins[i] = int'($urandom_range(255));
    run_frame(1, 3, 3, 1'b0);
    ramp_bins();
    run_frame(2, 5, 7, 1'b0);

    // Downstream stall: output must hold for 5 cycles, then be taken once.
    rdy_low = 1'b1;
    set_tbl(2, 5, 7);
    push_expected();
    fork
      stream_frame(int'(NBINS), 1'b1);
      begin
        wait_mel_valid();
        repeat (5) @(negedge clk);
        rdy_low = 1'b0;
      end
    join
    wait_done();

    // init after 3 bins of a frame: partial frame produces nothing.
    set_tbl(4, 5, 7);
    for (int i = 0; i < int'(NBINS); i++) frame_bins[i] = 50 + i;
    stream_frame(3, 1'b1);
    @(negedge clk);
    init = 1'b1;
    spect_valid = 1'b1;
    #4;
    check("init_spect_rdy", int'(spect_rdy0), 0);
    check("init_mel_valid", int'(mel_valid0), 0);
    @(negedge clk);
    init = 1'b0;
    spect_valid = 1'b0;
    ramp_bins();
    run_frame(4, 5, 7, 1'b0);

    // rst while a band output is pending.
    rdy_low = 1'b1;
    set_tbl(2, 5, 7);
    stream_frame(3, 1'b1);
    wait_mel_valid();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #4;
    check("rst_emit_mel_valid", int'(mel_valid0 | mel_valid1), 0);
    check("rst_emit_spect_rdy", int'(spect_rdy0), 0);
    rdy_low = 1'b0;
    run_frame(2, 5, 7, 1'b0);

    // Random tables (non-decreasing) and bins.
    for (int f = 0; f < 24; f++) begin
      int a;
      int b;
      int c;
      a = int'($urandom_range(7));
      b = a + int'($urandom_range(7 - a));
      c = b + int'($urandom_range(7 - b));
      for (int i = 0; i < int'(NBINS); i++) begin
        frame_bins[i] = ($urandom_range(1) != 0) ? int'($urandom_range(255, 150))
                                                 : int'($urandom_range(255));
      end
      run_frame(a, b, c, $urandom_range(1) != 0);
    end

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no end of test, required finish before %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
